// File: rtl/chdr_null_src_checker_if.sv
// CHDR AXI-Stream beat bus between the null source port and its checker.
interface chdr_null_src_checker_if #(
    parameter int CHDR_W = 64
);
    logic [CHDR_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, tlast, tvalid, input tready);
    modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/chdr_null_src_checker.sv
// Checks CHDR SeqNum continuity, header Length and the counting payload
// pattern of a null-source stream; never back-pressures while enabled.
module chdr_null_src_checker #(
    parameter int CHDR_W = 64,
    parameter int CNT_W  = 32,
    parameter int ERR_W  = 16
) (
    input  logic                     rfnoc_chdr_clk,
    input  logic                     rfnoc_chdr_rst,
    input  logic                     enable,
    input  logic                     clear,
    chdr_null_src_checker_if.slave   s_axis_chdr,
    output logic [CNT_W-1:0]         pkt_cnt,
    output logic [CNT_W-1:0]         line_cnt,
    output logic [ERR_W-1:0]         seq_err_cnt,
    output logic [ERR_W-1:0]         len_err_cnt,
    output logic [ERR_W-1:0]         data_err_cnt,
    output logic                     err,
    output logic                     busy
);
    localparam int          LANES = CHDR_W / 32;
    localparam logic [31:0] BYTES = 32'(CHDR_W / 8);

    typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DROP} state_e;

    state_e            state_q;
    logic              seq_arm_q, data_arm_q;
    logic [15:0]       exp_seq_q, line_idx_q, beats_q, len_q;
    logic [CNT_W-1:0]  pkt_q, line_q;
    logic [ERR_W-1:0]  seq_err_q, len_err_q, data_err_q;
    logic              err_q;

    logic              accept;
    logic [15:0]       hdr_seq, hdr_len, idx, beats_nx;
    logic [CHDR_W-1:0] exp_pat;
    logic              seq_bad, data_bad, len_bad_hdr, len_bad_pl;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    assign s_axis_chdr.tready = enable;

    always_comb begin
        accept      = s_axis_chdr.tvalid & enable;
        hdr_seq     = s_axis_chdr.tdata[47:32];
        hdr_len     = s_axis_chdr.tdata[31:16];
        // While armed, the beat itself supplies the line index it is checked against
        idx         = data_arm_q ? s_axis_chdr.tdata[15:0] : line_idx_q;
        exp_pat     = {LANES{~idx, idx}};
        data_bad    = (s_axis_chdr.tdata != exp_pat);
        seq_bad     = !seq_arm_q && (hdr_seq != exp_seq_q);
        beats_nx    = (beats_q == 16'hFFFF) ? 16'hFFFF : beats_q + 16'd1;
        len_bad_hdr = (32'(hdr_len) != BYTES);
        // A saturated beat count can never describe a real packet
        len_bad_pl  = (beats_nx == 16'hFFFF) || ((32'(beats_nx) * BYTES) != 32'(len_q));
    end

    always_ff @(posedge rfnoc_chdr_clk) begin
        if (rfnoc_chdr_rst) begin
            state_q    <= S_HDR;
            seq_arm_q  <= 1'b1;
            data_arm_q <= 1'b1;
            exp_seq_q  <= '0;
            line_idx_q <= '0;
            beats_q    <= '0;
            len_q      <= '0;
            pkt_q      <= '0;
            line_q     <= '0;
            seq_err_q  <= '0;
            len_err_q  <= '0;
            data_err_q <= '0;
            err_q      <= 1'b0;
        end else if (clear) begin
            pkt_q      <= '0;
            line_q     <= '0;
            seq_err_q  <= '0;
            len_err_q  <= '0;
            data_err_q <= '0;
            err_q      <= 1'b0;
            seq_arm_q  <= 1'b1;
            data_arm_q <= 1'b1;
            // The beat taken with clear is discarded; its packet tail is dropped
            if (accept)
                state_q <= s_axis_chdr.tlast ? S_HDR : S_DROP;
            else if (state_q == S_PAYLOAD)
                state_q <= S_DROP;
        end else if (accept) begin
            unique case (state_q)
                S_HDR: begin
                    exp_seq_q <= hdr_seq + 16'd1;
                    seq_arm_q <= 1'b0;
                    len_q     <= hdr_len;
                    beats_q   <= 16'd1;
                    if (seq_bad) begin
                        seq_err_q <= sat_inc(seq_err_q);
                        err_q     <= 1'b1;
                    end
                    if (s_axis_chdr.tlast) begin
                        pkt_q <= pkt_q + CNT_W'(1);
                        if (len_bad_hdr) begin
                            len_err_q <= sat_inc(len_err_q);
                            err_q     <= 1'b1;
                        end
                    end else begin
                        state_q <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    data_arm_q <= 1'b0;
                    line_idx_q <= idx + 16'd1;
                    line_q     <= line_q + CNT_W'(1);
                    beats_q    <= beats_nx;
                    if (data_bad) begin
                        data_err_q <= sat_inc(data_err_q);
                        err_q      <= 1'b1;
                    end
                    if (s_axis_chdr.tlast) begin
                        pkt_q   <= pkt_q + CNT_W'(1);
                        state_q <= S_HDR;
                        if (len_bad_pl) begin
                            len_err_q <= sat_inc(len_err_q);
                            err_q     <= 1'b1;
                        end
                    end
                end
                S_DROP: begin
                    if (s_axis_chdr.tlast)
                        state_q <= S_HDR;
                end
                default: state_q <= S_HDR;
            endcase
        end
    end

    assign pkt_cnt      = pkt_q;
    assign line_cnt     = line_q;
    assign seq_err_cnt  = seq_err_q;
    assign len_err_cnt  = len_err_q;
    assign data_err_cnt = data_err_q;
    assign err          = err_q;
    assign busy         = (state_q != S_HDR);
endmodule

// File: tb/tb_chdr_null_src_checker.sv
// Randomized bench for chdr_null_src_checker with a packet-level statistics model.
module tb_chdr_null_src_checker;
    localparam int CHDR_W = 64;
    localparam int CNT_W  = 32;
    localparam int ERR_W  = 16;
    localparam int BYTES  = CHDR_W / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic clear = 1'b0;
    logic [CNT_W-1:0] pkt_cnt, line_cnt;
    logic [ERR_W-1:0] seq_err_cnt, len_err_cnt, data_err_cnt;
    logic err, busy;

    always #5 clk = ~clk;

    chdr_null_src_checker_if #(.CHDR_W(CHDR_W)) s_if ();

    chdr_null_src_checker #(.CHDR_W(CHDR_W), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .rfnoc_chdr_clk (clk),
        .rfnoc_chdr_rst (rst),
        .enable         (enable),
        .clear          (clear),
        .s_axis_chdr    (s_if),
        .pkt_cnt        (pkt_cnt),
        .line_cnt       (line_cnt),
        .seq_err_cnt    (seq_err_cnt),
        .len_err_cnt    (len_err_cnt),
        .data_err_cnt   (data_err_cnt),
        .err            (err),
        .busy           (busy)
    );

    int tests = 0;
    int fails = 0;

    // Packet-level reference model
    int          m_pkt, m_line, m_seq_err, m_len_err, m_data_err;
    bit          m_err, m_seq_armed, m_data_armed;
    logic [15:0] m_exp_seq, m_idx;

    function automatic logic [CHDR_W-1:0] pat(input logic [15:0] i);
        logic [CHDR_W-1:0] v;
        for (int k = 0; k < CHDR_W / 32; k++) v[k*32 +: 32] = {~i, i};
        return v;
    endfunction

    function automatic logic [CHDR_W-1:0] hdr(input logic [15:0] seq, input logic [15:0] len);
        logic [CHDR_W-1:0] v;
        v = '0;
        v[47:32] = seq;
        v[31:16] = len;
        return v;
    endfunction

    task automatic m_clear();
        m_pkt = 0; m_line = 0; m_seq_err = 0; m_len_err = 0; m_data_err = 0;
        m_err = 0; m_seq_armed = 1; m_data_armed = 1; m_exp_seq = '0; m_idx = '0;
    endtask

    task automatic drive_beat(input logic [CHDR_W-1:0] d, input logic l, input logic c);
        int n;
        n = 0;
        @(negedge clk);
        s_if.tdata = d; s_if.tlast = l; s_if.tvalid = 1'b1; clear = c;
        forever begin
            @(posedge clk);
            if (s_if.tready) break;
            n++;
            if (n > 64) begin
                tests++; fails++;
                $display("FAIL beat_timeout: stalled %0d cycles, required accept", n);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; clear = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        s_if.tvalid = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_clear();
    endtask

    task automatic send_pkt(input logic [15:0] seq, input int npay, input logic [15:0] len,
                            input logic [15:0] seed, input int bad_beat, input int bad_bit,
                            input bit gaps);
        logic [15:0] base;
        logic [CHDR_W-1:0] d;
        base = m_data_armed ? seed : m_idx;
        drive_beat(hdr(seq, len), npay == 0, 1'b0);
        for (int b = 0; b < npay; b++) begin
            d = pat(base + 16'(b));
            if (b == bad_beat) d = d ^ (CHDR_W'(1) << bad_bit);
            if (gaps && $urandom_range(3) == 0) idle(1);
            drive_beat(d, b == npay - 1, 1'b0);
        end
        if (!m_seq_armed && seq != m_exp_seq) begin m_seq_err++; m_err = 1; end
        m_exp_seq = seq + 16'd1;
        m_seq_armed = 0;
        if (npay > 0) begin
            m_idx = base + 16'(npay);
            m_data_armed = 0;
            m_line += npay;
        end
        if (bad_beat >= 0 && bad_beat < npay) begin m_data_err++; m_err = 1; end
        if ((npay + 1) * BYTES != int'(len)) begin m_len_err++; m_err = 1; end
        m_pkt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({pkt_cnt, line_cnt, seq_err_cnt, len_err_cnt, data_err_cnt, err, busy} !== '0) begin
            fails++;
            $display("FAIL reset_state: pkt=%0d line=%0d seq=%0d len=%0d data=%0d err=%b busy=%b, required all 0",
                     pkt_cnt, line_cnt, seq_err_cnt, len_err_cnt, data_err_cnt, err, busy);
        end
        enable = 1'b0; #1;
        tests++;
        if (s_if.tready !== 1'b0) begin fails++; $display("FAIL tready_off: got %b need 0", s_if.tready); end
        enable = 1'b1; #1;
        tests++;
        if (s_if.tready !== 1'b1) begin fails++; $display("FAIL tready_on: got %b need 1", s_if.tready); end
        @(negedge clk);
        rst = 1'b0;
        m_clear();
    endtask

    task automatic run_clean_stream();
        for (int s = 5; s <= 14; s++) send_pkt(16'(s), 101, 16'd816, 16'h0000, -1, 0, 1'b0);
    endtask

    task automatic test_clean();
        run_clean_stream();
        idle(2);
        tests++;
        if (pkt_cnt !== CNT_W'(10) || line_cnt !== CNT_W'(1010)) begin
            fails++; $display("FAIL clean_counts: pkt=%0d line=%0d need 10/1010", pkt_cnt, line_cnt);
        end
        tests++;
        if ({seq_err_cnt, len_err_cnt, data_err_cnt, err} !== '0) begin
            fails++; $display("FAIL clean_errors: seq=%0d len=%0d data=%0d err=%b need 0",
                              seq_err_cnt, len_err_cnt, data_err_cnt, err);
        end
    endtask

    task automatic test_seq_len();
        do_clear();
        send_pkt(16'd0, 101, 16'd816, 16'h1234, -1, 0, 1'b0);
        send_pkt(16'd1, 101, 16'd816, 16'h0, -1, 0, 1'b0);
        send_pkt(16'd3, 101, 16'd816, 16'h0, -1, 0, 1'b0);
        send_pkt(16'd4, 100, 16'd816, 16'h0, -1, 0, 1'b0);
        idle(2);
        tests++;
        if (seq_err_cnt !== ERR_W'(m_seq_err) || len_err_cnt !== ERR_W'(m_len_err) || err !== m_err) begin
            fails++; $display("FAIL seq_len: seq=%0d len=%0d err=%b need %0d/%0d/%b",
                              seq_err_cnt, len_err_cnt, err, m_seq_err, m_len_err, m_err);
        end
        tests++;
        if (data_err_cnt !== '0 || pkt_cnt !== CNT_W'(m_pkt)) begin
            fails++; $display("FAIL seq_len_other: data=%0d pkt=%0d need 0/%0d", data_err_cnt, pkt_cnt, m_pkt);
        end
    endtask

    task automatic test_corrupt();
        do_clear();
        send_pkt(16'd20, 101, 16'd816, 16'($urandom), -1, 0, 1'b0);
        send_pkt(16'd21, 101, 16'd816, 16'h0, 37, 0, 1'b0);
        send_pkt(16'd22, 101, 16'd816, 16'h0, -1, 0, 1'b0);
        idle(2);
        tests++;
        if (data_err_cnt !== ERR_W'(1) || err !== 1'b1) begin
            fails++; $display("FAIL corrupt: data=%0d err=%b need 1/1", data_err_cnt, err);
        end
        tests++;
        if (line_cnt !== CNT_W'(m_line) || seq_err_cnt !== '0 || len_err_cnt !== '0) begin
            fails++; $display("FAIL corrupt_other: line=%0d seq=%0d len=%0d need %0d/0/0",
                              line_cnt, seq_err_cnt, len_err_cnt, m_line);
        end
    endtask

    task automatic test_wrap();
        do_clear();
        send_pkt(16'd7, 4, 16'd40, 16'hFFFE, -1, 0, 1'b0);
        send_pkt(16'd8, 3, 16'd32, 16'h0, -1, 0, 1'b0);
        idle(2);
        tests++;
        if (data_err_cnt !== '0 || line_cnt !== CNT_W'(7) || err !== 1'b0) begin
            fails++; $display("FAIL line_wrap: data=%0d line=%0d err=%b need 0/7/0", data_err_cnt, line_cnt, err);
        end
    endtask

    task automatic test_hdr_only();
        do_clear();
        send_pkt(16'd100, 0, 16'(BYTES), 16'h0, -1, 0, 1'b0);
        send_pkt(16'd101, 0, 16'(2 * BYTES), 16'h0, -1, 0, 1'b0);
        send_pkt(16'd102, 5, 16'(6 * BYTES), 16'($urandom), -1, 0, 1'b0);
        idle(2);
        tests++;
        if (pkt_cnt !== CNT_W'(m_pkt) || len_err_cnt !== ERR_W'(m_len_err) || busy !== 1'b0) begin
            fails++; $display("FAIL hdr_only: pkt=%0d len=%0d busy=%b need %0d/%0d/0",
                              pkt_cnt, len_err_cnt, busy, m_pkt, m_len_err);
        end
        tests++;
        if (seq_err_cnt !== '0 || data_err_cnt !== '0) begin
            fails++; $display("FAIL hdr_only_err: seq=%0d data=%0d need 0/0", seq_err_cnt, data_err_cnt);
        end
    endtask

    task automatic test_clear_mid();
        logic [15:0] seed;
        seed = 16'($urandom);
        drive_beat(hdr(m_exp_seq, 16'd816), 1'b0, 1'b0);
        for (int b = 0; b < 50; b++) drive_beat(pat(seed + 16'(b)), 1'b0, b == 49);
        m_clear();
        @(negedge clk);
        clear = 1'b0; s_if.tvalid = 1'b0;
        tests++;
        if ({pkt_cnt, line_cnt, seq_err_cnt, len_err_cnt, data_err_cnt, err} !== '0 || busy !== 1'b1) begin
            fails++; $display("FAIL clear_zero: pkt=%0d line=%0d err=%b busy=%b need 0/0/0/1",
                              pkt_cnt, line_cnt, err, busy);
        end
        for (int b = 0; b < 51; b++) drive_beat(CHDR_W'({$urandom, $urandom}), b == 50, 1'b0);
        idle(2);
        tests++;
        if (line_cnt !== '0 || pkt_cnt !== '0 || busy !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL clear_drop: line=%0d pkt=%0d busy=%b err=%b need 0/0/0/0",
                              line_cnt, pkt_cnt, busy, err);
        end
        send_pkt(16'($urandom), 10, 16'(11 * BYTES), 16'($urandom), -1, 0, 1'b0);
        idle(2);
        tests++;
        if (pkt_cnt !== CNT_W'(1) || line_cnt !== CNT_W'(10) ||
            {seq_err_cnt, len_err_cnt, data_err_cnt, err} !== '0) begin
            fails++; $display("FAIL clear_reseed: pkt=%0d line=%0d seq=%0d len=%0d data=%0d need 1/10/0/0/0",
                              pkt_cnt, line_cnt, seq_err_cnt, len_err_cnt, data_err_cnt);
        end
    endtask

    task automatic test_enable_toggle();
        bit done;
        int mism, cyc;
        done = 0; mism = 0; cyc = 0;
        do_clear();
        fork
            begin
                run_clean_stream();
                idle(2);
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    cyc++;
                    if (cyc % 3 == 0) enable = ~enable;
                end
                enable = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    if (s_if.tready !== enable) mism++;
                end
            end
        join
        @(negedge clk);
        tests++;
        if (mism != 0) begin fails++; $display("FAIL toggle_tready: %0d mismatched cycles, need 0", mism); end
        tests++;
        if (pkt_cnt !== CNT_W'(10) || line_cnt !== CNT_W'(1010) ||
            {seq_err_cnt, len_err_cnt, data_err_cnt, err} !== '0) begin
            fails++; $display("FAIL toggle_stats: pkt=%0d line=%0d seq=%0d len=%0d data=%0d need 10/1010/0/0/0",
                              pkt_cnt, line_cnt, seq_err_cnt, len_err_cnt, data_err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq, len;
        int npay, bad;
        do_clear();
        for (int p = 0; p < 30; p++) begin
            seq  = (m_seq_armed || $urandom_range(7) == 0) ? 16'($urandom) : m_exp_seq;
            npay = $urandom_range(20);
            len  = 16'((npay + 1) * BYTES + (($urandom_range(5) == 0) ? BYTES : 0));
            bad  = (npay >= 2 && $urandom_range(4) == 0) ? int'($urandom_range(npay - 1, 1)) : -1;
            send_pkt(seq, npay, len, 16'($urandom), bad, int'($urandom_range(CHDR_W - 1)), 1'b1);
        end
        idle(2);
        tests++;
        if (pkt_cnt !== CNT_W'(m_pkt) || line_cnt !== CNT_W'(m_line)) begin
            fails++; $display("FAIL b2b_counts: pkt=%0d line=%0d need %0d/%0d", pkt_cnt, line_cnt, m_pkt, m_line);
        end
        tests++;
        if (seq_err_cnt !== ERR_W'(m_seq_err) || len_err_cnt !== ERR_W'(m_len_err) ||
            data_err_cnt !== ERR_W'(m_data_err) || err !== m_err) begin
            fails++; $display("FAIL b2b_errors: seq=%0d len=%0d data=%0d err=%b need %0d/%0d/%0d/%b",
                              seq_err_cnt, len_err_cnt, data_err_cnt, err, m_seq_err, m_len_err, m_data_err, m_err);
        end
    endtask

    task automatic test_reset_mid();
        drive_beat(hdr(16'd9, 16'd816), 1'b0, 1'b0);
        for (int b = 0; b < 5; b++) drive_beat(pat(16'(b)), 1'b0, 1'b0);
        @(negedge clk);
        s_if.tvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || {pkt_cnt, line_cnt, err} !== '0) begin
            fails++; $display("FAIL reset_mid: busy=%b pkt=%0d line=%0d err=%b need 0/0/0/0",
                              busy, pkt_cnt, line_cnt, err);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean();
        test_seq_len();
        test_corrupt();
        test_wrap();
        test_hdr_only();
        test_clear_mid();
        test_enable_toggle();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/chdr_null_src_checker.md
# chdr_null_src_checker

Streaming CHDR consumer that sits directly downstream of the null source/sink block's source port and verifies its output. It checks CHDR header sequencing and length, and the counting payload pattern of every packet. It exposes packet, line and error statistics for benches and on-chip self-test. It never back-pressures while enabled, so it measures the source's full rate.

## Interface
Parameters:
- CHDR_W, 64, CHDR bus width in bits; must be a multiple of 32 and at least 64.
- CNT_W, 32, width of the packet and line counters.
- ERR_W, 16, width of each error counter.

Ports:
- rfnoc_chdr_clk  in  1  the only clock; all logic is in this domain.
- rfnoc_chdr_rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = accept beats; 0 = tready low, stream stalls.
- clear  in  1  single-cycle pulse; zeroes statistics and re-arms seeding.
- s_axis_chdr_tdata  in  CHDR_W  CHDR beat.
- s_axis_chdr_tlast  in  1  last beat of packet.
- s_axis_chdr_tvalid  in  1  beat valid.
- s_axis_chdr_tready  out  1  equals enable.
- pkt_cnt  out  CNT_W  packets completed (tlast accepted).
- line_cnt  out  CNT_W  payload beats accepted.
- seq_err_cnt  out  ERR_W  SeqNum discontinuities.
- len_err_cnt  out  ERR_W  header Length ≠ actual packet bytes.
- data_err_cnt  out  ERR_W  payload beats not matching the pattern.
- err  out  1  sticky OR of all error events since reset/clear.
- busy  out  1  1 while inside a packet (state ≠ S_HDR).

## Operation
- A beat is accepted when tvalid && tready. The header beat uses these fields: SeqNum = tdata[47:32], Length = tdata[31:16] in bytes including the header.
- Expected payload pattern for line index i (16-bit): 32-bit lane {~i, i}, replicated CHDR_W/32 times. i increments by 1 per accepted payload beat, wraps at 0xFFFF→0, and spans packet boundaries.
- Seeding: after reset or clear, `armed`=1.
  - The first header loads exp_seq from its own SeqNum. No seq check is made on that header.
  - The first payload beat loads i from tdata[15:0] and is checked against that seed.
  - `armed` clears after the first payload beat.
- After each header, exp_seq = SeqNum+1 mod 2^16. The next header's SeqNum is compared against exp_seq. A mismatch increments seq_err_cnt, and exp_seq still resyncs to SeqNum+1.
- The line index does not resync on a data error.
- Length check at tlast: beats×(CHDR_W/8), including the header, must equal Length. The beat counter is 16 bits and saturates at 0xFFFF, which forces a mismatch.
- FSM:
  - S_HDR: on header accept, capture Length, check seq, beats=1. If tlast is set, do the length check and stay in S_HDR; otherwise go to S_PAYLOAD.
  - S_PAYLOAD: on each accept, check data, line_cnt++, beats++. On tlast, do the length check, pkt_cnt++, and go to S_HDR.
  - S_DROP: accept beats without checking or counting. On tlast, go to S_HDR.
- Header-only packet: counted in pkt_cnt, and length-checked against CHDR_W/8.
- Clear:
  - Zeroes all counters and err, and sets armed.
  - In S_PAYLOAD, the state goes to S_DROP.
  - A beat accepted in the same cycle as clear is ignored for statistics and checks. If that beat has tlast, the state goes to S_HDR.
  - Clear and reset both take priority over a simultaneous beat.
- Error counters saturate at all-ones. pkt_cnt and line_cnt wrap.
- enable deasserted mid-packet only stalls the stream. State and expectations are held.

## Timing
- Reset values: all counters 0, err=0, busy=0, state S_HDR, armed=1, tready=enable.
- tready is a combinational copy of enable. No registered skid is used, and 100% throughput is supported.
- Statistics outputs are registered and reflect an accepted beat one cycle after acceptance. After clear, they read 0 on the following cycle.
- err asserts on the cycle after the offending beat and holds until reset or clear.
- Reset mid-packet: the state returns to S_HDR immediately. The remainder of that packet is then parsed as a new packet, and the checker may record errors; this is the expected behaviour.

## Test plan
- Clean stream: 10 packets, SeqNum 5..14, each with header + 101 payload beats, Length=816, pattern i=0x0000..0x03F1 → pkt_cnt=10, line_cnt=1010, all error counters 0, err=0.
- Sequence gap: SeqNum 0,1,3,4 → seq_err_cnt=1; Length 816 with 100 payload beats → len_err_cnt=1.
- Corrupt payload beat 37 of packet 2 (flip bit 0) → data_err_cnt=1. Later beats remain correct, so the count stays 1.
- Line wrap: seed i=0xFFFE, 4 payload beats → no data errors; i values seen are FFFE, FFFF, 0000, 0001.
- Clear mid-packet on payload beat 50 → counters read 0. The rest of the packet is dropped (line_cnt stays 0). The next packet seeds from its own values with no errors, and pkt_cnt=1 after it.
- enable toggled every 3 cycles with tvalid always high → tready follows enable, no beats are lost, and the statistics are identical to the clean stream.
